// File: rtl/mem_reader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_reader_pkg
//  Description : Shared types and constants for the memory stream reader.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_reader_pkg;

    localparam int c_DATA_W = 16;
    localparam int c_CYC_W  = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/mem_reader_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : mem_reader_fifo
//  Description : Synchronous FIFO with occupancy count and registered head.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_reader_fifo #(
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            flush,
    input  logic                            push,
    input  logic [DATA_W-1:0]               din,
    input  logic                            ready,
    output logic                            valid,
    output logic [DATA_W-1:0]               dout,
    output logic [$clog2(FIFO_DEPTH):0]     count
);

    localparam int c_PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [DATA_W-1:0]  r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               r_valid;
    logic [DATA_W-1:0]  r_data;

    logic               w_pop;
    logic               w_push_ok;
    logic [c_PTR_W-1:0] w_rd_next;
    logic [c_CNT_W-1:0] w_count_next;
    logic [DATA_W-1:0]  w_head_next;

    assign w_pop        = r_valid & ready;
    // A push into a full FIFO is still accepted when the head leaves this cycle
    assign w_push_ok    = push & ~flush & ((r_count != c_CNT_W'(FIFO_DEPTH)) | w_pop);
    assign w_rd_next    = w_pop ? r_rd_ptr + c_PTR_W'(1) : r_rd_ptr;
    assign w_count_next = r_count + c_CNT_W'(w_push_ok) - c_CNT_W'(w_pop);
    // Head register tracks the entry at the next read pointer, bypassing the array on a fresh write
    assign w_head_next  = (w_push_ok && (r_wr_ptr == w_rd_next)) ? din : r_mem[w_rd_next];

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_valid  <= 1'b0;
            r_data   <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_valid  <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            r_rd_ptr <= w_rd_next;
            r_count  <= w_count_next;
            r_valid  <= (w_count_next != '0);
            r_data   <= w_head_next;
        end
    end

    assign valid = r_valid;
    assign dout  = r_data;
    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/mem_stream_reader.sv
`default_nettype none
// ============================================================================
//  Module      : mem_stream_reader
//  Description : Burst read initiator for the sequential-address memory with
//                credit-controlled output FIFO. Optional abort via
//                MEM_STREAM_READER_ABORT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_stream_reader
    import mem_reader_pkg::*;
#(
    parameter int DATA_W     = c_DATA_W,
    parameter int LEN_W      = 10,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                reset,
`ifdef MEM_STREAM_READER_ABORT_EN
    input  logic                abort,
`endif
    input  logic                start,
    input  logic [LEN_W-1:0]    burst_len,
    input  logic                cfg_multi_cycle,
    input  logic [c_CYC_W-1:0]  cfg_cycle_count,
    output logic                busy,
    output logic                done,
    output logic                mem_rd_en,
    output logic                mem_multi_cycle_mode,
    output logic [c_CYC_W-1:0]  mem_cycle_count,
    input  logic [DATA_W-1:0]   mem_data_out,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [DATA_W-1:0]   m_data
);

    localparam int c_CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int c_SUM_W = c_CNT_W + 1;

    state_t             r_state;
    logic [LEN_W-1:0]   r_len_left;
    logic [c_CYC_W-1:0] r_cyc_left;
    logic [c_CYC_W-1:0] r_k;
    logic               r_mc;
    logic               r_rd_en;
    logic               r_busy;
    logic               r_done;
    logic               r_cap_pend;
    logic               r_abort_pend;

    logic               w_final;
    logic [LEN_W-1:0]   w_len_next;
    logic               w_pop;
    logic [c_SUM_W-1:0] w_count_next;
    logic               w_credit;
    logic               w_drained;
    logic               w_abort;
    logic               w_abort_any;
    logic [c_CYC_W-1:0] w_cost_m1;
    logic [c_CNT_W-1:0] w_fifo_count;
    logic               w_fifo_valid;

`ifdef MEM_STREAM_READER_ABORT_EN
    assign w_abort = abort & ((r_state == ISSUE) | (r_state == DRAIN));
`else
    assign w_abort = 1'b0;
`endif
    assign w_abort_any  = w_abort | r_abort_pend;

    assign w_final      = r_rd_en & (r_cyc_left == '0);
    assign w_len_next   = (w_final && (r_len_left != '0)) ? r_len_left - LEN_W'(1) : r_len_left;
    assign w_pop        = w_fifo_valid & m_ready;
    assign w_cost_m1    = r_mc ? r_k : '0;
    // Occupancy as seen next cycle; the word finishing now joins the in-flight credit
    assign w_count_next = {1'b0, w_fifo_count} + c_SUM_W'(r_cap_pend) - c_SUM_W'(w_pop);
    assign w_credit     = (w_count_next + c_SUM_W'(w_final)) < c_SUM_W'(FIFO_DEPTH);
    assign w_drained    = (w_count_next == '0) & ~r_cap_pend;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_len_left   <= '0;
            r_cyc_left   <= '0;
            r_k          <= '0;
            r_mc         <= 1'b0;
            r_rd_en      <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_cap_pend   <= 1'b0;
            r_abort_pend <= 1'b0;
        end else begin
            r_done     <= 1'b0;
            r_cap_pend <= w_final & ~w_abort_any;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_mc       <= cfg_multi_cycle;
                        r_k        <= cfg_cycle_count;
                        r_busy     <= 1'b1;
                        r_len_left <= burst_len;
                        if (burst_len == '0) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state    <= ISSUE;
                            r_rd_en    <= 1'b1;
                            r_cyc_left <= cfg_multi_cycle ? cfg_cycle_count : '0;
                        end
                    end
                end
                ISSUE: begin
                    r_len_left <= w_len_next;
                    if (r_rd_en && !w_final) begin
                        r_cyc_left <= r_cyc_left - c_CYC_W'(1);
                    end
                    // An aborted word still finishes so the memory's cycle counter lands on zero
                    if (w_abort_any) begin
                        if (r_rd_en && !w_final) begin
                            r_abort_pend <= 1'b1;
                        end else begin
                            r_rd_en      <= 1'b0;
                            r_abort_pend <= 1'b0;
                            r_state      <= DONE;
                            r_done       <= 1'b1;
                        end
                    end else if (w_final && (w_len_next == '0)) begin
                        r_rd_en <= 1'b0;
                        r_state <= DRAIN;
                    end else if ((!r_rd_en || w_final) && w_credit) begin
                        r_rd_en    <= 1'b1;
                        r_cyc_left <= w_cost_m1;
                    end else if (w_final) begin
                        r_rd_en <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (w_abort_any || w_drained) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                    end
                end
                DONE: begin
                    r_state      <= IDLE;
                    r_busy       <= 1'b0;
                    r_abort_pend <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    mem_reader_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (w_abort_any),
        .push  (r_cap_pend),
        .din   (mem_data_out),
        .ready (m_ready),
        .valid (w_fifo_valid),
        .dout  (m_data),
        .count (w_fifo_count)
    );

    assign busy                 = r_busy;
    assign done                 = r_done;
    assign mem_rd_en            = r_rd_en;
    assign mem_multi_cycle_mode = r_mc;
    assign mem_cycle_count      = r_k;
    assign m_valid              = w_fifo_valid;

endmodule
`default_nettype wire

// File: doc/mem_stream_reader.md
# mem_stream_reader

Read-side initiator for the team's sequential-address on-chip memory. It accepts a burst request, drives the memory's `rd_en`, `multi_cycle_mode` and `cycle_count` inputs with exact per-word cycle timing, and captures `data_out` on the correct cycle. Captured words go into a small FIFO that feeds a valid/ready stream toward the neural-engine datapath, so downstream stalls never lose a word.

## Interface
- `DATA_W`, 16: memory word width.
- `LEN_W`, 10: burst-length width. Maximum burst is 2^LEN_W-1 words.
- `FIFO_DEPTH`, 4: output FIFO entries. Must be a power of two and at least 2.

Ports:
- `clk` in 1: single clock; all logic is on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle request. Sampled only in IDLE.
- `burst_len` in LEN_W: number of words to read. Latched on `start`.
- `cfg_multi_cycle` in 1: read mode. Latched on `start`.
- `cfg_cycle_count` in 2: extra wait cycles K per word. Latched on `start`.
- `busy` out 1: high from the cycle after an accepted `start` through the `done` cycle.
- `done` out 1: one-cycle pulse at burst end.
- `mem_rd_en` out 1: drives the memory `rd_en`.
- `mem_multi_cycle_mode` out 1: latched mode.
- `mem_cycle_count` out 2: latched K.
- `mem_data_out` in DATA_W: memory read data.
- `m_valid` out 1: output stream valid.
- `m_ready` in 1: output stream ready.
- `m_data` out DATA_W: output stream data.

## Operation
- FSM states are IDLE, ISSUE, DRAIN and DONE.
  - IDLE → ISSUE on `start` with `burst_len`≠0.
  - IDLE → DONE on `start` with `burst_len`=0. No read is issued.
  - ISSUE → DRAIN when the last word's final `rd_en` cycle has been issued.
  - DRAIN → DONE when there is no word in flight, the FIFO is empty and no word is being pushed.
  - DONE → IDLE unconditionally.
- Word cost is C = 1 in single mode and C = K+1 in multi-cycle mode. Each word gets C contiguous `mem_rd_en` cycles. `mem_rd_en` never drops mid-word.
- Word-start rule: a new word may start only when `fifo_count + inflight < FIFO_DEPTH`.
  - `inflight` counts words whose final `rd_en` cycle has issued but which are not yet pushed.
  - This credit rule guarantees the FIFO never overflows, so no push is ever dropped.
- Capture: if the final `rd_en` cycle of a word is cycle t, `mem_data_out` is sampled at the end of cycle t+1 and pushed into the FIFO.
- A mirror counter of remaining `rd_en` cycles in the current word (0..K) tracks the memory's internal cycle counter.
- Words-remaining counter: LEN_W bits. It decrements on each word's final `rd_en` cycle and never wraps below 0.
- The FIFO performs a simultaneous push and pop in the same cycle when full: the pop frees the slot and the push is accepted.
- `start` during `busy` is ignored. Configuration changes during `busy` have no effect.
- Reset mid-burst:
  - All state clears and `mem_rd_en` returns to 0 on the next edge.
  - The memory's own counters must be reset by the top level in the same cycle; the memory reset is tied from the same source.
- Reset values: `busy`=0, `done`=0, `mem_rd_en`=0, `mem_multi_cycle_mode`=0, `mem_cycle_count`=0, `m_valid`=0, `m_data`=0. The FIFO is empty.

## Timing
- `start` sampled high at cycle 0 gives `busy`=1 and the first `mem_rd_en`=1 in cycle 1.
- Single mode with `m_ready`=1 and FIFO_DEPTH≥3:
  - `mem_rd_en` stays high for N consecutive cycles.
  - The first `m_valid` appears in cycle 3.
  - Throughput is one word per cycle.
- Multi-cycle mode: `mem_rd_en` stays high for K+1 cycles per word. Words are pushed every K+1 cycles.
- `m_data` and `m_valid` are registered FIFO head outputs. A handshake is `m_valid & m_ready`.
- `done` pulses in the cycle after the last handshake. `busy` is low from the following cycle.

## Configuration
- `MEM_STREAM_READER_ABORT_EN` defined: adds input port `abort` (1 bit), sampled in ISSUE and DRAIN.
  - No new word starts after `abort` is sampled.
  - A word already in progress completes its C `rd_en` cycles, so the memory's cycle counter ends at 0.
  - After `abort`, the FIFO and in-flight words are discarded, `m_valid` drops, and the FSM goes to DONE.
- `MEM_STREAM_READER_ABORT_EN` undefined: no `abort` port exists and bursts always run to completion.

## Structure
- Package `mem_reader_pkg` holds:
  - the FSM state enum (`IDLE`, `ISSUE`, `DRAIN`, `DONE`);
  - the `DATA_W` default;
  - the cycle-count width constant (2).
- Sub-module `mem_reader_fifo` is a synchronous FIFO parameterised by DATA_W and FIFO_DEPTH, with count output and registered head.
- The top level contains the FSM, word and cycle counters, in-flight tracking and credit logic.

## Test plan
- Single mode, memory preloaded 0x0100..0x0107, `burst_len`=8, `m_ready`=1:
  - `mem_rd_en` high in cycles 1–8.
  - `m_data` = 0x0100..0x0107 in cycles 3–10.
  - `done` in cycle 11.
- Multi-cycle mode, K=2, `burst_len`=3:
  - `mem_rd_en` high for 9 contiguous cycles.
  - Exactly 3 words are output, in order.
- Backpressure: single mode, FIFO_DEPTH=4, `burst_len`=10, `m_ready`=0 for 20 cycles, then 1:
  - `mem_rd_en` stops after 4 words.
  - No word is lost or duplicated, and all 10 words arrive in order.
- `burst_len`=0:
  - No `mem_rd_en`.
  - `busy` for one cycle, `done` in cycle 1.
- Reset asserted in cycle 5 of an 8-word burst:
  - All outputs are at reset values next cycle.
  - A new 2-word burst then returns the next two memory words correctly.
- With `MEM_STREAM_READER_ABORT_EN` defined, K=1, `abort` in the first `rd_en` cycle of word 2:
  - `mem_rd_en` stays high one more cycle, then 0.
  - FIFO flushed, `m_valid`=0, `done` pulses.
